// File: rtl/alu_exec_stage.sv
// Registered LEGv8 execute stage: single-cycle logic/arith ops plus an iterative
// shift-add multiplier, with valid/ready handshakes on both sides.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no result held, ready for a new operation
// MUL   | shift-add multiply iterating, one partial-product step per clock
// DONE  | result/zero valid and held until downstream consumes them
module alu_exec_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_acc_next;

    always_comb begin
        w_alu = '0;
        case (alu_ctrl)
            OP_AND:  w_alu = a & b;
            OP_ORR:  w_alu = a | b;
            OP_ADD:  w_alu = a + b;
            OP_SUB:  w_alu = a - b;
            OP_PASS: w_alu = b;
            default: w_alu = '0;
        endcase
    end

    // Accumulator value after the current step; on the last step it is the product.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == MUL);
    assign result    = r_result;
    assign zero      = r_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (alu_ctrl == OP_MUL) begin
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= MUL;
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            r_state  <= DONE;
                        end
                    end else if (r_state == DONE && out_ready) begin
                        r_state <= IDLE;
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    // Fixed WIDTH steps, no early exit even if the multiplier runs out of ones.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_result <= w_acc_next;
                        r_zero   <= (w_acc_next == '0);
                        r_state  <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: a transaction-level model compared every
// cycle, plus directed vectors with literal expected results.
module tb_alu_exec_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   alu_ctrl = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_ctrl(alu_ctrl),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero),
        .busy(busy)
    );

    function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Spec-level arithmetic; MUL uses the native product truncated to W bits.
    function automatic logic [W-1:0] spec_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0111: r = y;
            4'b1000: r = x * y;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Transaction model: a held result, and a countdown of cycles left for a pending multiply.
    logic         m_have = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_res = '0;
    logic         m_zero = 1'b0;
    logic [W-1:0] m_pend = '0;
    wire          m_rdy = !rst && ((!m_have && m_left == 0) || (m_have && out_ready));

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_have = 1'b0;
            m_left = 0;
            m_res  = '0;
            m_zero = 1'b0;
            m_pend = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_have = 1'b1;
                m_res  = m_pend;
                m_zero = (m_pend == '0);
            end
        end else if (in_valid && m_rdy) begin
            if (alu_ctrl == 4'b1000) begin
                m_pend = spec_op(alu_ctrl, a, b);
                m_left = W;
                m_have = 1'b0;
            end else begin
                m_res  = spec_op(alu_ctrl, a, b);
                m_zero = (m_res == '0);
                m_have = 1'b1;
            end
        end else if (m_have && out_ready) begin
            m_have = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_out_valid", W'(out_valid), W'(m_have));
        chk("cyc_busy", W'(busy), W'(m_left > 0));
        chk("cyc_in_ready", W'(in_ready), W'(m_rdy));
        chk("cyc_result", result, m_res);
        chk("cyc_zero", W'(zero), W'(m_zero));
    end

    // Present an op and hold it until accepted; returns 2 time units after the accepting edge.
    task automatic send(input logic [3:0] c, input logic [W-1:0] aa, input logic [W-1:0] bb);
        logic rdy;
        bit   ok;
        ok = 0;
        in_valid = 1'b1;
        alu_ctrl = c;
        a = aa;
        b = bb;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        #2;
        in_valid = 1'b0;
        chk("accept_timeout", W'(ok), W'(1));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    typedef struct {
        logic [3:0]   c;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int acc_cyc;
        int prev_cyc;
        int lat;

        vecs[0] = '{4'b0010, 64'd5, 64'd7, 64'd12, 1'b0};
        vecs[1] = '{4'b0110, 64'd9, 64'd9, 64'd0, 1'b1};
        vecs[2] = '{4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0};
        vecs[3] = '{4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0};
        vecs[4] = '{4'b0111, 64'd123, 64'd0, 64'd0, 1'b1};
        vecs[5] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1};
        vecs[6] = '{4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[7] = '{4'b1111, 64'hFF, 64'hFF, 64'd0, 1'b1};

        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_result", result, '0);
        chk("rst_zero", W'(zero), W'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("ready_after_rst", W'(in_ready), W'(1));

        // Back-to-back single-cycle ops, one result per cycle.
        out_ready = 1'b1;
        prev_cyc = 0;
        foreach (vecs[i]) begin
            send(vecs[i].c, vecs[i].x, vecs[i].y);
            acc_cyc = cyc;
            chk($sformatf("vec%0d_result", i), result, vecs[i].r);
            chk($sformatf("vec%0d_zero", i), W'(zero), W'(vecs[i].z));
            chk($sformatf("vec%0d_valid", i), W'(out_valid), W'(1));
            if (i > 0) chk($sformatf("vec%0d_rate", i), W'(acc_cyc - prev_cyc), W'(1));
            prev_cyc = acc_cyc;
        end
        @(posedge clk);
        #2 chk("drained", W'(out_valid), W'(0));

        // Multiplies: fixed W-cycle latency, second one accepted back-to-back.
        send(4'b1000, 64'h1234, 64'h10);
        chk("mul_busy", W'(busy), W'(1));
        chk("mul_in_ready", W'(in_ready), W'(0));
        wait_valid(lat);
        chk("mul1_latency", W'(lat), W'(W));
        chk("mul1_result", result, 64'h12340);
        chk("mul1_zero", W'(zero), W'(0));
        send(4'b1000, 64'h8000_0000_0000_0000, 64'd2);
        wait_valid(lat);
        chk("mul2_latency", W'(lat), W'(W));
        chk("mul2_result", result, 64'd0);
        chk("mul2_zero", W'(zero), W'(1));
        @(posedge clk);
        #2;

        // Backpressure holds the result and blocks the next op until out_ready rises.
        out_ready = 1'b0;
        send(4'b0010, 64'd3, 64'd4);
        chk("bp_result0", result, 64'd7);
        in_valid = 1'b1;
        alu_ctrl = 4'b0001;
        a = 64'h100;
        b = 64'h1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            chk("bp_hold_result", result, 64'd7);
            chk("bp_hold_in_ready", W'(in_ready), W'(0));
            chk("bp_hold_valid", W'(out_valid), W'(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        chk("bp_release_result", result, 64'h101);
        chk("bp_release_valid", W'(out_valid), W'(1));
        in_valid = 1'b0;
        @(posedge clk);
        #2;

        // Reset in the middle of a multiply discards it.
        send(4'b1000, 64'hFFFF, 64'hFFFF);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_out_valid", W'(out_valid), W'(0));
        chk("mrst_result", result, '0);
        chk("mrst_busy", W'(busy), W'(0));
        chk("mrst_in_ready", W'(in_ready), W'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("mrst_ready_after", W'(in_ready), W'(1));
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #2 chk("mrst_no_stale", W'(out_valid), W'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
